cam_lookup_table: RTL

//  Parametrised key->value lookup engine: CAM compare plus value RAM in one block, one clock.
//  - Replaces the bare cam_top + ram16x32 chain.
//  - Adds a request/result handshake, backpressure and priority resolution.
//  - Adds per-entry valid bits, bulk clear, and a config write port for the control plane.
//  - Sits between the packet parser (key source) and the action stage (value sink).

---
 rtl/cam_lookup_table.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cam_lookup_table.sv
// Key->value CAM lookup: two-stage pipeline (S1 compare, S2 priority encode + value read) with handshakes.
// Optional ternary match via `define CAM_TERNARY_EN (per-entry don't-care mask); default build is exact match.
module cam_lookup_table #(
  parameter  int KEY_W  = 4,
  parameter  int VAL_W  = 32,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic              res_multi,
  output logic [ADDR_W-1:0] res_addr,
  output logic [VAL_W-1:0]  res_value,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_entry_v,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [KEY_W-1:0]  wr_mask,
  input  logic [VAL_W-1:0]  wr_value,
  input  logic              clr
);

  logic [DEPTH-1:0] entry_v;
  logic [KEY_W-1:0] key_mem  [DEPTH];
  logic [VAL_W-1:0] val_mem  [DEPTH];
  logic [KEY_W-1:0] mask_eff [DEPTH];

  logic             stall;
  logic             s1_valid;
  logic [DEPTH-1:0] s1_match;
  logic [DEPTH-1:0] match_vec;
  logic [ADDR_W-1:0] enc_addr;
  logic             enc_hit;
  logic             enc_multi;
  logic [VAL_W-1:0] rd_value;

  assign stall     = res_valid & ~res_ready;
  assign key_ready = ~stall;

  // Storage arrays are deliberately not reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_addr] <= wr_key;
      val_mem[wr_addr] <= wr_value;
    end
  end

`ifdef CAM_TERNARY_EN
  logic [KEY_W-1:0] mask_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mask_mem[wr_addr] <= wr_mask;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mask_eff[i] = mask_mem[i];
  end
`else
  logic unused_mask;
  assign unused_mask = ^wr_mask;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mask_eff[i] = '0;
  end
`endif

  // A write to wr_addr overrides a simultaneous bulk clear for that one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr) entry_v[i] <= 1'b0;
        if (wr_en && (wr_addr == ADDR_W'(i))) entry_v[i] <= wr_entry_v;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      match_vec[i] = entry_v[i] & (((key ^ key_mem[i]) & ~mask_eff[i]) == '0);
  end

  always_comb begin
    enc_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (s1_match[i]) enc_addr = ADDR_W'(i);
  end

  // Clearing the lowest set bit leaves something only if two or more bits matched.
  assign enc_hit   = |s1_match;
  assign enc_multi = |(s1_match & (s1_match - DEPTH'(1)));
  assign rd_value  = enc_hit ? val_mem[enc_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_match  <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_multi <= 1'b0;
      res_addr  <= '0;
      res_value <= '0;
    end else if (!stall) begin
      s1_valid  <= key_valid;
      s1_match  <= key_valid ? match_vec : '0;
      res_valid <= s1_valid;
      res_hit   <= enc_hit;
      res_multi <= enc_multi;
      res_addr  <= enc_addr;
      res_value <= rd_value;
    end
  end

endmodule
